// File: rtl/fft_reorder.sv
// Bit-reversed to natural-order reorder buffer for the SDF FFT output, ping-pong over two banks.
// Optional REORDER_SOP_EN adds a do_sop start-of-frame flag aligned with output index 0.
module fft_reorder #(
    parameter int N     = 64,
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    input  logic             adjust,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im,
    output logic             err
`ifdef REORDER_SOP_EN
    ,
    output logic             do_sop
`endif
);

    localparam int LOG_N = $clog2(N);

    typedef logic [LOG_N-1:0] idx_t;
    typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_t;

    localparam idx_t LAST_FULL = idx_t'(N - 1);
    localparam idx_t LAST_ADJ  = idx_t'(N / 4 - 1);

    // Short frames never set the top two count bits, so the full reversal shifted down by two
    // equals the reversal over LOG_N-2 bits.
    function automatic idx_t bit_rev(input idx_t v, input logic short_mode);
        idx_t r;
        for (int i = 0; i < LOG_N; i++) r[i] = v[LOG_N-1-i];
        return short_mode ? (r >> 2) : r;
    endfunction

    logic [2*WIDTH-1:0] mem [2*N];
    logic [2*WIDTH-1:0] rd_data;

    idx_t       wr_cnt;
    logic       wr_bank;
    logic       wr_mode;
    logic       wr_drop;
    logic [1:0] full;
    logic [1:0] bank_mode;

    state_t     state, state_n;
    logic       rd_bank, rd_bank_n;
    idx_t       rd_cnt, rd_cnt_n;
    logic       rd_mode, rd_mode_n;

    logic       first, cur_mode, wr_last, busy, drop_now, wr_en;
    logic       rd_en, rd_last;
    logic [1:0] full_set, rd_clr;
    idx_t       wr_addr;

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        first    = di_en && (wr_cnt == '0);
        cur_mode = first ? adjust : wr_mode;
        wr_last  = di_en && (wr_cnt == (cur_mode ? LAST_ADJ : LAST_FULL));
        rd_en    = (state == READ);
        rd_last  = rd_en && (rd_cnt == (rd_mode ? LAST_ADJ : LAST_FULL));
        rd_clr   = rd_last ? (2'b01 << rd_bank) : 2'b00;
        // A bank whose readout finishes this very cycle is free for a frame starting now.
        busy     = full[wr_bank] && !rd_clr[wr_bank];
        drop_now = first ? busy : wr_drop;
        wr_en    = di_en && !drop_now;
        full_set = (wr_last && !drop_now) ? (2'b01 << wr_bank) : 2'b00;
        wr_addr  = bit_rev(wr_cnt, cur_mode);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_cnt    <= '0;
            wr_bank   <= 1'b0;
            wr_mode   <= 1'b0;
            wr_drop   <= 1'b0;
            full      <= 2'b00;
            bank_mode <= 2'b00;
            err       <= 1'b0;
        end else begin
            if (!di_en || wr_last) wr_cnt <= '0;
            else                   wr_cnt <= wr_cnt + idx_t'(1);

            if (first) wr_mode <= adjust;
            if (first && !busy) bank_mode[wr_bank] <= adjust;

            if (!di_en || wr_last) wr_drop <= 1'b0;
            else if (first)        wr_drop <= busy;

            if (full_set != 2'b00) wr_bank <= ~wr_bank;

            // Set and clear may both fire on one edge; on the same bank the clear wins.
            full <= (full | full_set) & ~rd_clr;
            err  <= first && busy;
        end
    end

    always_comb begin
        state_n   = state;
        rd_bank_n = rd_bank;
        rd_cnt_n  = rd_cnt;
        rd_mode_n = rd_mode;
        case (state)
            IDLE: begin
                if (full != 2'b00) begin
                    state_n   = READ;
                    // With both banks full the write pointer points back at the older one.
                    rd_bank_n = (full == 2'b11) ? wr_bank : full[1];
                    rd_cnt_n  = '0;
                    rd_mode_n = bank_mode[rd_bank_n];
                end
            end
            READ: begin
                rd_cnt_n = rd_cnt + idx_t'(1);
                if (rd_last) begin
                    rd_cnt_n = '0;
                    if (full[~rd_bank]) begin
                        rd_bank_n = ~rd_bank;
                        rd_mode_n = bank_mode[~rd_bank];
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            rd_bank <= 1'b0;
            rd_cnt  <= '0;
            rd_mode <= 1'b0;
        end else begin
            state   <= state_n;
            rd_bank <= rd_bank_n;
            rd_cnt  <= rd_cnt_n;
            rd_mode <= rd_mode_n;
        end
    end

    // NOTE: the storage array has no reset so it maps onto block RAM; only the control state
    // and the output register are cleared.
    always_ff @(posedge clock) begin
        if (wr_en) mem[{wr_bank, wr_addr}] <= {di_re, di_im};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
            do_en   <= 1'b0;
        end else begin
            do_en <= rd_en;
            if (rd_en) rd_data <= mem[{rd_bank, rd_cnt}];
        end
    end

    assign do_re = rd_data[2*WIDTH-1:WIDTH];
    assign do_im = rd_data[WIDTH-1:0];

`ifdef REORDER_SOP_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) do_sop <= 1'b0;
        else       do_sop <= rd_en && (rd_cnt == '0);
    end
`endif

endmodule
